// File: rtl/cpu_types_pkg.sv
// Shared MIPS encodings and the per-stage control word for the pipelined datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] RA_IDX = 5'd31;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDIU = 6'h09,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    F_JR   = 6'h08,
    F_ADDU = 6'h21,
    F_SUBU = 6'h23,
    F_AND  = 6'h24,
    F_OR   = 6'h25,
    F_SLT  = 6'h2A
  } funct_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } aluop_t;

  typedef struct packed {
    logic                 valid;
    logic                 reg_wen;
    logic [REG_IDX_W-1:0] wsel;
    logic                 mem_to_reg;
    logic                 dmem_ren;
    logic                 dmem_wen;
    aluop_t               alu_op;
    logic                 alu_src;
    logic                 ext_op;
    logic                 upper_imm;
    logic                 is_halt;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decoder.sv
// Combinational ID-stage decode: instruction -> control word, branch/jump class, reads_rt.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; unknown opcode/funct or instr_valid=0 yields a bubble.
// Ports: instr/instr_valid in; ctrl, is_beq/is_bne/is_j/is_jal/is_jr, reads_rt, rs, rt out.
module control_decoder
  import cpu_types_pkg::*;
(
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  output ctrl_word_t           ctrl,
  output logic                 is_beq,
  output logic                 is_bne,
  output logic                 is_j,
  output logic                 is_jal,
  output logic                 is_jr,
  output logic                 reads_rt,
  output logic [REG_IDX_W-1:0] rs,
  output logic [REG_IDX_W-1:0] rt
);

  logic [5:0]           op;
  logic [5:0]           fn;
  logic [REG_IDX_W-1:0] rd;
  logic                 shamt_unused;
  logic                 known;
  logic                 r_alu;
  ctrl_word_t           c;
  logic                 beq, bne, j, jal, jr;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign fn = instr[5:0];
  assign shamt_unused = ^instr[10:6];

  always_comb begin
    c        = CTRL_BUBBLE;
    known    = 1'b0;
    r_alu    = 1'b0;
    reads_rt = 1'b0;
    beq      = 1'b0;
    bne      = 1'b0;
    j        = 1'b0;
    jal      = 1'b0;
    jr       = 1'b0;
    case (op)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        case (fn)
          F_ADDU: begin known = 1'b1; r_alu = 1'b1; c.alu_op = ALU_ADD; end
          F_SUBU: begin known = 1'b1; r_alu = 1'b1; c.alu_op = ALU_SUB; end
          F_AND:  begin known = 1'b1; r_alu = 1'b1; c.alu_op = ALU_AND; end
          F_OR:   begin known = 1'b1; r_alu = 1'b1; c.alu_op = ALU_OR;  end
          F_SLT:  begin known = 1'b1; r_alu = 1'b1; c.alu_op = ALU_SLT; end
          F_JR:   begin known = 1'b1; jr = 1'b1; end
          default: ;
        endcase
        if (r_alu) begin
          c.reg_wen = 1'b1;
          c.wsel    = rd;
        end
      end
      OP_ADDIU: begin
        known = 1'b1; c.reg_wen = 1'b1; c.wsel = rt;
        c.alu_src = 1'b1; c.ext_op = 1'b1; c.alu_op = ALU_ADD;
      end
      OP_ANDI: begin
        known = 1'b1; c.reg_wen = 1'b1; c.wsel = rt;
        c.alu_src = 1'b1; c.alu_op = ALU_AND;
      end
      OP_ORI: begin
        known = 1'b1; c.reg_wen = 1'b1; c.wsel = rt;
        c.alu_src = 1'b1; c.alu_op = ALU_OR;
      end
      OP_LUI: begin
        known = 1'b1; c.reg_wen = 1'b1; c.wsel = rt;
        c.alu_src = 1'b1; c.upper_imm = 1'b1; c.alu_op = ALU_ADD;
      end
      OP_LW: begin
        known = 1'b1; c.reg_wen = 1'b1; c.wsel = rt;
        c.mem_to_reg = 1'b1; c.dmem_ren = 1'b1;
        c.alu_src = 1'b1; c.ext_op = 1'b1; c.alu_op = ALU_ADD;
      end
      OP_SW: begin
        known = 1'b1; reads_rt = 1'b1; c.dmem_wen = 1'b1;
        c.alu_src = 1'b1; c.ext_op = 1'b1; c.alu_op = ALU_ADD;
      end
      OP_BEQ: begin
        known = 1'b1; reads_rt = 1'b1; beq = 1'b1;
        c.ext_op = 1'b1; c.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        known = 1'b1; reads_rt = 1'b1; bne = 1'b1;
        c.ext_op = 1'b1; c.alu_op = ALU_SUB;
      end
      OP_J:    begin known = 1'b1; j = 1'b1; end
      OP_JAL:  begin known = 1'b1; jal = 1'b1; c.reg_wen = 1'b1; c.wsel = RA_IDX; end
      OP_HALT: begin known = 1'b1; c.is_halt = 1'b1; end
      default: ;
    endcase
    c.valid = known & instr_valid;
    // $0 is hard-wired; never let a write to it reach the register file.
    if (c.wsel == '0) c.reg_wen = 1'b0;
    if (!c.valid) c = CTRL_BUBBLE;
  end

  assign ctrl   = c;
  assign is_beq = beq & ctrl.valid;
  assign is_bne = bne & ctrl.valid;
  assign is_j   = j   & ctrl.valid;
  assign is_jal = jal & ctrl.valid;
  assign is_jr  = jr  & ctrl.valid;

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipelined MIPS control: decode, DEPTH-stage control-word shift, load-use stall, ID branch resolve, HALT drain.
// Latency: decoded word on ex_ctrl after 1 edge, wb_ctrl after DEPTH edges.
// Backpressure: mem_wait freezes every stage and holds IF/ID; load-use inserts one bubble.
// Ports: CLK/RST; instr, instr_valid, equal, mem_wait in; ex/mem/wb_ctrl, id_stall, id_flush,
//        pc_src, jtype, jreg, halt out.
module pipeline_control_unit
  import cpu_types_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_W  = REG_IDX_W,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] instr,
  input  logic              instr_valid,
  input  logic              equal,
  input  logic              mem_wait,
  output ctrl_word_t        ex_ctrl,
  output ctrl_word_t        mem_ctrl,
  output ctrl_word_t        wb_ctrl,
  output logic              id_stall,
  output logic              id_flush,
  output logic              pc_src,
  output logic              jtype,
  output logic              jreg,
  output logic              halt
);

  ctrl_word_t       stage [DEPTH];
  ctrl_word_t       dec_ctrl;
  ctrl_word_t       s0_next;
  logic             is_beq, is_bne, is_j, is_jal, is_jr, reads_rt;
  logic [REG_W-1:0] id_rs, id_rt;
  logic             halting;
  logic             halt_q;
  logic             ld_use;
  logic             take;
  logic             wb_halt;

  control_decoder u_dec (
    .instr       (instr[31:0]),
    .instr_valid (instr_valid),
    .ctrl        (dec_ctrl),
    .is_beq      (is_beq),
    .is_bne      (is_bne),
    .is_j        (is_j),
    .is_jal      (is_jal),
    .is_jr       (is_jr),
    .reads_rt    (reads_rt),
    .rs          (id_rs),
    .rt          (id_rt)
  );

  assign ex_ctrl  = stage[0];
  assign mem_ctrl = stage[1];
  assign wb_ctrl  = stage[DEPTH-1];

  // Load in EX whose destination feeds the ID instruction: one bubble.
  assign ld_use = dec_ctrl.valid && ex_ctrl.valid && ex_ctrl.dmem_ren &&
                  (ex_ctrl.wsel != '0) &&
                  ((ex_ctrl.wsel == id_rs) || (reads_rt && ex_ctrl.wsel == id_rt));

  assign s0_next = (halting || ld_use) ? CTRL_BUBBLE : dec_ctrl;

  assign take    = (is_beq && equal) || (is_bne && !equal) || is_j || is_jal || is_jr;
  assign wb_halt = wb_ctrl.valid && wb_ctrl.is_halt;

  // mem_wait folds into id_stall, which in turn suppresses branch/jump redirects.
  assign id_stall = !RST && (mem_wait || ld_use || halting);
  assign pc_src   = !RST && !id_stall && take;
  assign id_flush = pc_src;
  assign jtype    = pc_src && (is_j || is_jal);
  assign jreg     = pc_src && is_jr;
  assign halt     = !RST && (halt_q || wb_halt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= CTRL_BUBBLE;
      halting <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      if (!mem_wait) begin
        stage[0] <= s0_next;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        if (s0_next.valid && s0_next.is_halt) halting <= 1'b1;
      end
      if (wb_halt) halt_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit with a wb-side scoreboard.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: mem_wait exercised mid-stream; scoreboard pops only on advancing edges.
module tb_pipeline_control_unit;
  import cpu_types_pkg::*;

  localparam int DEPTH = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic [31:0] instr;
  logic       instr_valid;
  logic       equal;
  logic       mem_wait;
  ctrl_word_t ex_ctrl, mem_ctrl, wb_ctrl;
  logic       id_stall, id_flush, pc_src, jtype, jreg, halt;

  int checks   = 0;
  int failures = 0;
  ctrl_word_t exp_q [$];

  pipeline_control_unit #(.DEPTH(DEPTH), .REG_W(5), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .instr(instr), .instr_valid(instr_valid), .equal(equal),
    .mem_wait(mem_wait), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .id_stall(id_stall), .id_flush(id_flush), .pc_src(pc_src), .jtype(jtype),
    .jreg(jreg), .halt(halt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
    r_ins = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    i_ins = {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Expected control words, written out field by field from the instruction semantics.
  function automatic ctrl_word_t w_alu_r(input int rd);
    ctrl_word_t w = CTRL_BUBBLE;
    w.valid = 1'b1; w.wsel = 5'(rd); w.reg_wen = (rd != 0); w.alu_op = ALU_ADD;
    return w;
  endfunction

  function automatic ctrl_word_t w_lw(input int rt);
    ctrl_word_t w = CTRL_BUBBLE;
    w.valid = 1'b1; w.reg_wen = 1'b1; w.wsel = 5'(rt); w.mem_to_reg = 1'b1;
    w.dmem_ren = 1'b1; w.alu_src = 1'b1; w.ext_op = 1'b1; w.alu_op = ALU_ADD;
    return w;
  endfunction

  function automatic ctrl_word_t w_sw();
    ctrl_word_t w = CTRL_BUBBLE;
    w.valid = 1'b1; w.dmem_wen = 1'b1; w.alu_src = 1'b1; w.ext_op = 1'b1; w.alu_op = ALU_ADD;
    return w;
  endfunction

  function automatic ctrl_word_t w_branch();
    ctrl_word_t w = CTRL_BUBBLE;
    w.valid = 1'b1; w.ext_op = 1'b1; w.alu_op = ALU_SUB;
    return w;
  endfunction

  function automatic ctrl_word_t w_plain(input logic jal, input logic hlt);
    ctrl_word_t w = CTRL_BUBBLE;
    w.valid = 1'b1;
    if (jal) begin w.reg_wen = 1'b1; w.wsel = 5'd31; end
    w.is_halt = hlt;
    return w;
  endfunction

  // Scoreboard: on every advancing edge, a valid wb word must match the oldest issued word.
  always @(posedge CLK) begin
    logic adv;
    ctrl_word_t e;
    adv = !RST && !mem_wait;
    #2;
    if (adv && wb_ctrl.valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_wb", 32'(wb_ctrl), 32'(CTRL_BUBBLE));
      end else begin
        e = exp_q.pop_front();
        chk("sb_wb_order", 32'(wb_ctrl), 32'(e));
      end
    end
  end

  task automatic bubble();
    instr = $urandom; instr_valid = 1'b0;
  endtask

  initial begin
    ctrl_word_t w_ld, w_ad, w_s, w_jmp;
    RST = 1'b1; instr = $urandom; instr_valid = 1'b1; equal = 1'b0; mem_wait = 1'b0;

    // 1. reset
    for (int i = 0; i < 2; i++) begin
      tick();
      instr = $urandom;
      chk("rst_ex_valid",  32'(ex_ctrl.valid), 0);
      chk("rst_mem_valid", 32'(mem_ctrl.valid), 0);
      chk("rst_wb_valid",  32'(wb_ctrl.valid), 0);
      chk("rst_halt",      32'(halt), 0);
      chk("rst_id_stall",  32'(id_stall), 0);
      chk("rst_pc_src",    32'(pc_src), 0);
    end
    RST = 1'b0; bubble();
    tick();

    // 2. ADDU latency and $0 write suppression
    instr = r_ins(1, 2, 3, F_ADDU); instr_valid = 1'b1; exp_q.push_back(w_alu_r(3));
    tick(); bubble();
    chk("addu_ex", 32'(ex_ctrl), 32'(w_alu_r(3)));
    tick();
    chk("addu_mem", 32'(mem_ctrl), 32'(w_alu_r(3)));
    chk("addu_ex_bubble", 32'(ex_ctrl.valid), 0);
    tick();
    chk("addu_wb", 32'(wb_ctrl), 32'(w_alu_r(3)));
    instr = r_ins(1, 2, 0, F_ADDU); instr_valid = 1'b1; exp_q.push_back(w_alu_r(0));
    tick(); bubble();
    chk("addu0_ex", 32'(ex_ctrl), 32'(w_alu_r(0)));
    chk("addu0_reg_wen", 32'(ex_ctrl.reg_wen), 0);
    tick(); tick();

    // 3. load-use hazard, then no hazard
    w_ld = w_lw(4); w_ad = w_alu_r(6);
    instr = i_ins(OP_LW, 5, 4, 16'h0000); instr_valid = 1'b1; exp_q.push_back(w_ld);
    tick();
    instr = r_ins(4, 7, 6, F_ADDU); exp_q.push_back(w_ad);
    #1 chk("lu_stall", 32'(id_stall), 1);
    chk("lu_no_flush", 32'(id_flush), 0);
    tick();
    chk("lu_ex_bubble", 32'(ex_ctrl), 32'(CTRL_BUBBLE));
    chk("lu_mem_lw", 32'(mem_ctrl), 32'(w_ld));
    chk("lu_stall_one", 32'(id_stall), 0);
    tick(); bubble();
    chk("lu_ex_addu", 32'(ex_ctrl), 32'(w_ad));
    instr = i_ins(OP_LW, 5, 4, 16'h0000); instr_valid = 1'b1; exp_q.push_back(w_ld);
    tick();
    instr = r_ins(8, 7, 6, F_ADDU); exp_q.push_back(w_ad);
    #1 chk("nolu_stall", 32'(id_stall), 0);
    tick(); bubble();
    chk("nolu_ex_addu", 32'(ex_ctrl), 32'(w_ad));
    tick(); tick();

    // 4. branch / jump resolution
    instr = i_ins(OP_BEQ, 1, 2, 16'h0004); instr_valid = 1'b1; equal = 1'b1;
    exp_q.push_back(w_branch());
    #1 chk("beq_t_pc_src", 32'(pc_src), 1);
    chk("beq_t_flush", 32'(id_flush), 1);
    chk("beq_t_jtype", 32'(jtype), 0);
    chk("beq_t_jreg",  32'(jreg), 0);
    tick();
    equal = 1'b0; exp_q.push_back(w_branch());
    #1 chk("beq_nt", 32'({pc_src, id_flush, jtype, jreg}), 0);
    tick();
    instr = r_ins(31, 0, 0, F_JR); exp_q.push_back(w_plain(1'b0, 1'b0));
    #1 chk("jr_pc_src", 32'(pc_src), 1);
    chk("jr_jreg",  32'(jreg), 1);
    chk("jr_jtype", 32'(jtype), 0);
    tick();
    instr = {6'(OP_JAL), 26'h0000100}; exp_q.push_back(w_plain(1'b1, 1'b0));
    #1 chk("jal_pc_src", 32'(pc_src), 1);
    chk("jal_jtype", 32'(jtype), 1);
    tick(); bubble();
    chk("jal_ex_wsel", 32'(ex_ctrl.wsel), 31);
    chk("jal_ex_reg_wen", 32'(ex_ctrl.reg_wen), 1);
    tick(); tick();

    // 5. mem_wait freeze with LW, ADDU, SW in flight
    w_s = w_sw(); w_jmp = w_plain(1'b0, 1'b0);
    instr = i_ins(OP_LW, 5, 4, 16'h0000); instr_valid = 1'b1; exp_q.push_back(w_ld);
    tick();
    instr = r_ins(8, 7, 6, F_ADDU); exp_q.push_back(w_ad);
    tick();
    instr = i_ins(OP_SW, 10, 9, 16'h0004); exp_q.push_back(w_s);
    tick();
    mem_wait = 1'b1; instr = {6'(OP_J), 26'h0000040};
    #1 chk("mw_stall", 32'(id_stall), 1);
    chk("mw_no_redirect", 32'({pc_src, id_flush, jtype, jreg}), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mw_ex_hold",  32'(ex_ctrl),  32'(w_s));
      chk("mw_mem_hold", 32'(mem_ctrl), 32'(w_ad));
      chk("mw_wb_hold",  32'(wb_ctrl),  32'(w_ld));
    end
    mem_wait = 1'b0; exp_q.push_back(w_jmp);
    #1 chk("mw_rel_stall", 32'(id_stall), 0);
    chk("mw_rel_jump", 32'({pc_src, jtype}), 32'b11);
    tick(); bubble();
    chk("mw_rel_ex",  32'(ex_ctrl),  32'(w_jmp));
    chk("mw_rel_mem", 32'(mem_ctrl), 32'(w_s));
    chk("mw_rel_wb",  32'(wb_ctrl),  32'(w_ad));
    tick(); tick();

    // 6. HALT drain
    instr = {6'(OP_HALT), 26'd0}; instr_valid = 1'b1; exp_q.push_back(w_plain(1'b0, 1'b1));
    tick();
    chk("halt_ex", 32'(ex_ctrl), 32'(w_plain(1'b0, 1'b1)));
    chk("halt_early0", 32'(halt), 0);
    instr = r_ins(1, 2, 12, F_ADDU);
    #1 chk("halt_id_stall", 32'(id_stall), 1);
    for (int i = 2; i <= DEPTH; i++) begin
      tick();
      chk("halt_edge", 32'(halt), 32'(i == DEPTH));
      chk("halt_ex_bubble", 32'(ex_ctrl.valid), 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_sticky", 32'(halt), 1);
      chk("halt_no_addu", 32'({ex_ctrl.valid, mem_ctrl.valid, wb_ctrl.valid}), 0);
    end
    RST = 1'b1;
    #1 chk("halt_rst_comb", 32'(halt), 0);
    tick();
    chk("halt_rst_edge", 32'(halt), 0);
    chk("halt_rst_wb", 32'(wb_ctrl), 32'(CTRL_BUBBLE));
    RST = 1'b0; bubble();
    tick();
    chk("halt_after_rst", 32'(halt), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
